// File: rtl/scr1_dmem_tgt_bridge.sv
// Dmem router port terminator: turns each SCR1 dmem transfer into a single
// outstanding req/ack access with byte enables toward a simple target.
// Illegal, misaligned and timed-out accesses are answered with RDY_ER.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_tgt_pkg;
  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'b00,
    SCR1_MEM_CMD_WR    = 2'b01,
    SCR1_MEM_CMD_ERROR = 2'b11
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_tgt_bridge
  import scr1_dmem_tgt_pkg::*;
#(
  parameter int AWIDTH     = `SCR1_DMEM_AWIDTH,
  parameter int DWIDTH     = `SCR1_DMEM_DWIDTH,
  parameter int TIMEOUT    = 255,
  parameter int TIMEOUT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dmem_req,
  output logic                 dmem_req_ack,
  input  type_scr1_mem_cmd_e   dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [AWIDTH-1:0]    dmem_addr,
  input  logic [DWIDTH-1:0]    dmem_wdata,
  output logic [DWIDTH-1:0]    dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp,
  output logic                 tgt_req,
  output logic                 tgt_we,
  output logic [AWIDTH-1:0]    tgt_addr,
  output logic [3:0]           tgt_be,
  output logic [DWIDTH-1:0]    tgt_wdata,
  input  logic                 tgt_ack,
  input  logic [DWIDTH-1:0]    tgt_rdata,
  input  logic                 tgt_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  // Last counter value before the watchdog fires (counter starts at 0).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_r;
  logic [15:0] cnt_r;
  logic        bad_s;
  logic [3:0]  be_s;
  logic        timeout_s;

  // Accept only when idle; the router holds dmem_req until this goes high.
  assign dmem_req_ack = (state_r == IDLE);

  // Legality check and byte-enable decode of the incoming transfer.
  always_comb begin
    bad_s = 1'b0;
    be_s  = 4'b0000;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE: begin
        be_s = 4'b0001 << dmem_addr[1:0];
      end
      SCR1_MEM_WIDTH_HWORD: begin
        be_s  = dmem_addr[1] ? 4'b1100 : 4'b0011;
        bad_s = dmem_addr[0];
      end
      SCR1_MEM_WIDTH_WORD: begin
        be_s  = 4'b1111;
        bad_s = (dmem_addr[1:0] != 2'b00);
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
    if (dmem_cmd == SCR1_MEM_CMD_ERROR) begin
      bad_s = 1'b1;
    end else begin
      bad_s = bad_s;
    end
  end

  // Watchdog fires on the last allowed BUSY cycle; a same-cycle ack wins.
  assign timeout_s = (TIMEOUT_EN != 0) && (cnt_r == CNT_LAST);

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      tgt_req    <= 1'b0;
      tgt_we     <= 1'b0;
      tgt_addr   <= '0;
      tgt_be     <= 4'b0000;
      tgt_wdata  <= '0;
      dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_rdata <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dmem_req) begin
            if (bad_s) begin
              // Error accesses never reach the target.
              dmem_resp  <= SCR1_MEM_RESP_RDY_ER;
              dmem_rdata <= '0;
              state_r    <= RESP;
            end else begin
              tgt_req   <= 1'b1;
              tgt_we    <= (dmem_cmd == SCR1_MEM_CMD_WR);
              tgt_addr  <= {dmem_addr[AWIDTH-1:2], 2'b00};
              tgt_be    <= be_s;
              tgt_wdata <= dmem_wdata;
              state_r   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (tgt_ack) begin
            tgt_req    <= 1'b0;
            cnt_r      <= 16'd0;
            dmem_resp  <= tgt_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            dmem_rdata <= tgt_we ? '0 : tgt_rdata;
            state_r    <= RESP;
          end else if (timeout_s) begin
            tgt_req    <= 1'b0;
            cnt_r      <= 16'd0;
            dmem_resp  <= SCR1_MEM_RESP_RDY_ER;
            dmem_rdata <= '0;
            state_r    <= RESP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        RESP: begin
          dmem_resp <= SCR1_MEM_RESP_NOTRDY;
          state_r   <= IDLE;
        end
        default: begin
          tgt_req   <= 1'b0;
          cnt_r     <= 16'd0;
          dmem_resp <= SCR1_MEM_RESP_NOTRDY;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_dmem_tgt_bridge.sv
// Scoreboard bench for scr1_dmem_tgt_bridge (TIMEOUT = 4).

module tb_scr1_dmem_tgt_bridge;
  import scr1_dmem_tgt_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          tgt_cycles;
    int          resp_cycle;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 dmem_req;
  logic                 dmem_req_ack;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic                 tgt_req;
  logic                 tgt_we;
  logic [31:0]          tgt_addr;
  logic [3:0]           tgt_be;
  logic [31:0]          tgt_wdata;
  logic                 tgt_ack;
  logic [31:0]          tgt_rdata;
  logic                 tgt_err;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  scr1_dmem_tgt_bridge #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TO), .TIMEOUT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack),
    .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr),
    .tgt_be(tgt_be), .tgt_wdata(tgt_wdata),
    .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata), .tgt_err(tgt_err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One transfer: push expectation, drive it, act as target acking on its
  // k-th tgt_req cycle (k=0 never acks), then pop and compare the response.
  task automatic do_xfer(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e wid,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int k, input logic err, input logic [31:0] rd);
    exp_t e;
    logic legal;
    int   tc;
    int   resp_n;
    int   w;
    legal = (cmd != SCR1_MEM_CMD_ERROR) && (wid != SCR1_MEM_WIDTH_ERROR) &&
            !(wid == SCR1_MEM_WIDTH_HWORD && addr[0]) &&
            !(wid == SCR1_MEM_WIDTH_WORD && addr[1:0] != 2'b00);
    case (wid)
      SCR1_MEM_WIDTH_BYTE:  e.be = 4'b0001 << addr[1:0];
      SCR1_MEM_WIDTH_HWORD: e.be = addr[1] ? 4'b1100 : 4'b0011;
      default:              e.be = 4'b1111;
    endcase
    e.addr  = addr & 32'hFFFF_FFFC;
    e.we    = (cmd == SCR1_MEM_CMD_WR);
    e.wdata = wd;
    if (!legal) begin
      e.resp = 2'b10; e.rdata = 32'h0; e.tgt_cycles = 0; e.resp_cycle = 1;
    end else if (k == 0 || k > TO) begin
      e.resp = 2'b10; e.rdata = 32'h0; e.tgt_cycles = TO; e.resp_cycle = TO + 1;
    end else begin
      e.resp = err ? 2'b10 : 2'b01;
      e.rdata = e.we ? 32'h0 : rd;
      e.tgt_cycles = k; e.resp_cycle = k + 1;
    end
    exp_q.push_back(e);

    w = 0;
    while (!dmem_req_ack && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ack_ready", 64'(dmem_req_ack), 64'd1);
    dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = wid; dmem_addr = addr; dmem_wdata = wd;

    tc = 0;
    resp_n = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        dmem_req = 1'b0;
      end
      if (dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
        resp_n = n;
        break;
      end
      if (tgt_req) begin
        tc++;
        chk("tgt_addr", 64'(tgt_addr), 64'(e.addr));
        chk("tgt_be", 64'(tgt_be), 64'(e.be));
        chk("tgt_we", 64'(tgt_we), 64'(e.we));
        chk("tgt_wdata", 64'(tgt_wdata), 64'(e.wdata));
      end
      tgt_ack = tgt_req && (tc == k);
      tgt_rdata = rd;
      tgt_err = err;
    end
    tgt_ack = 1'b0;
    tgt_err = 1'b0;

    e = exp_q.pop_front();
    chk("resp_cycle", 64'(resp_n), 64'(e.resp_cycle));
    chk("tgt_cycles", 64'(tc), 64'(e.tgt_cycles));
    chk("resp", 64'(dmem_resp), 64'(e.resp));
    chk("rdata", 64'(dmem_rdata), 64'(e.rdata));
    chk("req_ack_in_resp", 64'(dmem_req_ack), 64'd0);
    @(negedge clk);
    chk("resp_after", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    chk("rdata_hold", 64'(dmem_rdata), 64'(e.rdata));
    chk("req_ack_back", 64'(dmem_req_ack), 64'd1);
  endtask

  initial begin
    rst = 1'b1; dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = 32'h0; dmem_wdata = 32'h0;
    tgt_ack = 1'b0; tgt_rdata = 32'h0; tgt_err = 1'b0;

    // Reset held two cycles with a pending request.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_tgt_req", 64'(tgt_req), 64'd0);
      chk("rst_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_rdata", 64'(dmem_rdata), 64'd0);
      chk("rst_be", 64'(tgt_be), 64'd0);
    end
    rst = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk("idle_req_ack", 64'(dmem_req_ack), 64'd1);
    chk("idle_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));

    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0001_0004, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
    do_xfer(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h0000_0103, 32'hAB00_0000, 1, 1'b0, 32'h5555_5555);
    do_xfer(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0000_0102, 32'hCDEF_0000, 2, 1'b0, 32'h0);
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h0000_0101, 32'h0, 1, 1'b0, 32'h1122_3344);
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h0000_0200, 32'h0, 1, 1'b0, 32'hA5A5_0F0F);
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0000_0102, 32'h0, 1, 1'b0, 32'h0);
    do_xfer(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0000_0101, 32'h0, 1, 1'b0, 32'h0);
    do_xfer(SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h0000_0100, 32'h0, 1, 1'b0, 32'h0);
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, 32'h0000_0100, 32'h0, 1, 1'b0, 32'h0);
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0000_0300, 32'h0, 1, 1'b1, 32'h1234_5678);
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0000_0400, 32'h0, 0, 1'b0, 32'hFFFF_FFFF);
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0000_0404, 32'h0, TO, 1'b0, 32'h0BAD_F00D);
    do_xfer(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h0000_0408, 32'h0102_0304, 0, 1'b0, 32'h0);

    // Randomised legal and illegal transfers.
    for (int i = 0; i < 8; i++) begin
      do_xfer(type_scr1_mem_cmd_e'(2'($urandom_range(0, 1))),
              type_scr1_mem_width_e'(2'($urandom_range(0, 3))),
              $urandom, $urandom, $urandom_range(0, TO), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset in the middle of a BUSY access.
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr = 32'h0000_0800;
    @(negedge clk);
    dmem_req = 1'b0;
    chk("mid_busy_req", 64'(tgt_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tgt_req", 64'(tgt_req), 64'd0);
    chk("mid_rst_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    chk("mid_rst_idle", 64'(dmem_req_ack), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    do_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000_0804, 32'h0, 2, 1'b0, 32'hCAFE_BABE);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
